bldc_commutation_engine: RTL and testbench
==========================================

// Module: bldc_commutation_engine
// PURPOSE
//  Parametrised successor to the single-width BLDC commutation/PWM stage. Turns a 3-bit hall code into six gate drives.
//  PWM-chops the high side and inserts per-phase programmable dead time. Measures the hall edge period as speed feedback.
//  Latches invalid-hall and stall faults. Sits between the PI controller's duty output and the inverter gate pins.
// PARAMETERS
//  PWM_W       12  PWM counter/duty width; PWM period = 2**PWM_W clocks
//  DEADTIME_W  6   dead-time counter width
//  PERIOD_W    24  hall-period/stall counter width
// PORTS
//  i_clk           in   1           system clock
//  i_reset         in   1           asynchronous, active-high reset
//  i_enable        in   1           run request
//  i_rot_ccw       in   1           1 = counter-clockwise commutation
//  i_duty          in   PWM_W       high-side duty (compare value)
//  i_deadtime      in   DEADTIME_W  dead-time length, clocks
//  i_stall_limit   in   PERIOD_W    stall timeout, clocks; 0 disables the stall check
//  i_fault_clear   in   1           fault acknowledge
//  i_hall_state    in   3           raw asynchronous hall inputs {C,B,A}
//  o_U_hi/o_U_lo, o_V_hi/o_V_lo, o_W_hi/o_W_lo  out  1 each  gate drives
//  o_pwm_sync      out  1           1-clk pulse when PWM counter = 0
//  o_hall_period   out  PERIOD_W    clocks between last two valid hall edges
//  o_period_valid  out  1           1-clk pulse when o_hall_period updates
//  o_fault         out  2           00 none, 01 invalid hall, 10 stall
//  o_state         out  2           00 IDLE, 01 RUN, 10 FAULT
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, sync flops 0.
//  Hall path: 2-FF synchroniser -> registered decode -> per-phase dead-time stage -> registered gates.
//  With i_deadtime = 0, an i_hall_state change reaches the gates in 4 clocks; otherwise 4 + i_deadtime clocks.
//  CW table (hall -> HI phase, LO phase): 001 U,V; 011 U,W; 010 V,W; 110 V,U; 100 W,U; 101 W,V.
//  CCW swaps the HI and LO roles. The third phase is OFF.
//  PWM: free-running PWM_W-bit up-counter that wraps.
//  - HI phase: x_hi = (cnt < i_duty) and x_lo = 0. LO phase: x_lo = 1 constantly.
//  - i_duty = 0 gives hi never on. Max duty = (2**PWM_W-1)/2**PWM_W. i_duty is sampled every clock.
//  Dead time: each phase has a requested state in {OFF, HI, LO}.
//  - On any change of request, both gates of that phase go 0 and a counter loads i_deadtime.
//  - The new state is applied once the counter reaches 0. A further change mid-count reloads the counter.
//  - x_hi and x_lo are never both 1, under any input.
//  FSM:
//  - IDLE: gates 0. Enter RUN when i_enable = 1 and the synced hall is valid (not 000/111).
//  - RUN: synced hall 000/111 -> FAULT with code 01.
//  - RUN: period counter >= i_stall_limit (limit != 0) -> FAULT with code 10.
//  - RUN: i_enable = 0 -> IDLE.
//  - A fault and i_enable = 0 in the same cycle -> FAULT (fault wins).
//  - FAULT: gates forced 0 the same clock the state is entered, bypassing dead time. o_fault holds its code.
//  - FAULT exits to IDLE only on i_fault_clear = 1 with i_enable = 0, which also clears o_fault to 00.
//  - i_fault_clear is ignored while i_enable = 1.
//  Period: counter increments every clock in RUN and saturates at all-ones (no wrap).
//  - On a valid->valid synced hall change: o_hall_period <= counter, o_period_valid pulses, counter <= 1.
//  - The first edge after entering RUN only restarts the counter (no valid pulse).
//  - The counter clears on leaving RUN. o_hall_period holds its last value in IDLE/FAULT.
//  Asynchronous reset mid-operation drops all gates to 0 immediately.
// TESTING
//  1 Reset, enable, hall=001, CW, duty=0x400, deadtime=0 -> U_hi high 1024 of every 4096 clks, V_lo=1, W off, U_lo=0.
//  2 hall 001->011 with deadtime=10 -> V_lo falls 4 clks after the change, W_lo rises 14 clks after it; U_hi unaffected.
//  3 Step hall through 6 CW codes every 5000 clks -> o_period_valid on edges 2..6, o_hall_period=5000; hi&lo never both 1.
//  4 hall=111 in RUN -> o_state=10, o_fault=01, all gates 0; clear with enable=1 ignored; clear with enable=0 -> IDLE.
//  5 stall_limit=1000, hold hall constant -> FAULT code 10 after 1000 clks; stall_limit=0 -> never faults.
//  6 i_rot_ccw=1, hall=001 -> V_hi chopped, U_lo=1; assert i_reset mid-PWM-high -> all outputs 0 same cycle.

Source files
------------

// File: rtl/bldc_commutation_engine_if.sv
// bldc_commutation_engine_if: control, feedback and gate-drive bundle of the BLDC commutation engine.
interface bldc_commutation_engine_if #(
    parameter int PWM_W      = 12,
    parameter int DEADTIME_W = 6,
    parameter int PERIOD_W   = 24
);
    logic                  i_enable;
    logic                  i_rot_ccw;
    logic [PWM_W-1:0]      i_duty;
    logic [DEADTIME_W-1:0] i_deadtime;
    logic [PERIOD_W-1:0]   i_stall_limit;
    logic                  i_fault_clear;
    logic [2:0]            i_hall_state;
    logic                  o_U_hi, o_U_lo, o_V_hi, o_V_lo, o_W_hi, o_W_lo;
    logic                  o_pwm_sync;
    logic [PERIOD_W-1:0]   o_hall_period;
    logic                  o_period_valid;
    logic [1:0]            o_fault;
    logic [1:0]            o_state;

    modport master (
        output i_enable, i_rot_ccw, i_duty, i_deadtime, i_stall_limit, i_fault_clear, i_hall_state,
        input  o_U_hi, o_U_lo, o_V_hi, o_V_lo, o_W_hi, o_W_lo,
        input  o_pwm_sync, o_hall_period, o_period_valid, o_fault, o_state
    );

    modport slave (
        input  i_enable, i_rot_ccw, i_duty, i_deadtime, i_stall_limit, i_fault_clear, i_hall_state,
        output o_U_hi, o_U_lo, o_V_hi, o_V_lo, o_W_hi, o_W_lo,
        output o_pwm_sync, o_hall_period, o_period_valid, o_fault, o_state
    );
endinterface

// File: rtl/bldc_commutation_engine.sv
// bldc_commutation_engine: hall-driven six-step commutation with high-side PWM, per-phase dead time,
// hall period measurement and latched invalid-hall / stall faults.
module bldc_commutation_engine #(
    parameter int PWM_W      = 12,
    parameter int DEADTIME_W = 6,
    parameter int PERIOD_W   = 24
) (
    input logic                      i_clk,
    input logic                      i_reset,
    bldc_commutation_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FAULT = 2'b10} state_e;
    localparam logic [1:0] PH_OFF = 2'd0, PH_HI = 2'd1, PH_LO = 2'd2;

    // Per-phase requests packed {W,V,U}; CCW swaps the HI/LO code bits of each phase.
    function automatic logic [5:0] decode(input logic [2:0] h, input logic ccw);
        logic [5:0] t;
        case (h)
            3'b001:  t = {PH_OFF, PH_LO, PH_HI};
            3'b011:  t = {PH_LO, PH_OFF, PH_HI};
            3'b010:  t = {PH_LO, PH_HI, PH_OFF};
            3'b110:  t = {PH_OFF, PH_HI, PH_LO};
            3'b100:  t = {PH_HI, PH_OFF, PH_LO};
            3'b101:  t = {PH_HI, PH_LO, PH_OFF};
            default: t = '0;
        endcase
        return ccw ? {t[4], t[5], t[2], t[3], t[0], t[1]} : t;
    endfunction

    logic [2:0]          hall_s1_q, hall_s2_q, hall_s3_q;
    logic [5:0]          dec_q;
    state_e              state_q;
    logic [1:0]          fault_q;
    logic [PWM_W-1:0]    pwm_q;
    logic                sync_q;
    logic [PERIOD_W-1:0] per_cnt_q, period_q;
    logic                per_valid_q, seen_q;
    logic [2:0]          hi, lo;
    logic                hall_ok, hall_ok_prev, hall_edge, stall_hit, run_nx, pwm_on;

    assign hall_ok      = hall_s2_q != 3'b000 && hall_s2_q != 3'b111;
    assign hall_ok_prev = hall_s3_q != 3'b000 && hall_s3_q != 3'b111;
    assign hall_edge    = hall_ok && hall_ok_prev && hall_s2_q != hall_s3_q;
    assign stall_hit    = bus.i_stall_limit != '0 && per_cnt_q >= bus.i_stall_limit;
    assign pwm_on       = pwm_q < bus.i_duty;
    // Gates may only drive while the next state is RUN, so leaving RUN zeroes them on the same edge.
    assign run_nx       = (state_q == RUN) ? hall_ok && !stall_hit && bus.i_enable
                                           : state_q == IDLE && hall_ok && bus.i_enable;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hall_s1_q <= '0;
            hall_s2_q <= '0;
            hall_s3_q <= '0;
            dec_q     <= '0;
            pwm_q     <= '0;
            sync_q    <= 1'b0;
        end else begin
            hall_s1_q <= bus.i_hall_state;
            hall_s2_q <= hall_s1_q;
            hall_s3_q <= hall_s2_q;
            dec_q     <= decode(hall_s2_q, bus.i_rot_ccw);
            pwm_q     <= pwm_q + PWM_W'(1);
            sync_q    <= &pwm_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            fault_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: if (bus.i_enable && hall_ok) state_q <= RUN;
                RUN: begin
                    if (!hall_ok) begin
                        state_q <= FAULT;
                        fault_q <= 2'b01;
                    end else if (stall_hit) begin
                        state_q <= FAULT;
                        fault_q <= 2'b10;
                    end else if (!bus.i_enable) begin
                        state_q <= IDLE;
                    end
                end
                FAULT: if (bus.i_fault_clear && !bus.i_enable) begin
                    state_q <= IDLE;
                    fault_q <= 2'b00;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            per_cnt_q   <= '0;
            period_q    <= '0;
            per_valid_q <= 1'b0;
            seen_q      <= 1'b0;
        end else begin
            per_valid_q <= 1'b0;
            if (state_q != RUN) begin
                per_cnt_q <= '0;
                seen_q    <= 1'b0;
            end else if (hall_edge) begin
                per_cnt_q <= PERIOD_W'(1);
                seen_q    <= 1'b1;
                if (seen_q) begin
                    period_q    <= per_cnt_q;
                    per_valid_q <= 1'b1;
                end
            end else if (~&per_cnt_q) begin
                per_cnt_q <= per_cnt_q + PERIOD_W'(1);
            end
        end
    end

    for (genvar p = 0; p < 3; p++) begin : g_ph
        logic [1:0]            req, tgt_q;
        logic [DEADTIME_W-1:0] dt_q;
        logic                  hi_q, lo_q;
        assign req = dec_q[2*p +: 2];
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                tgt_q <= PH_OFF;
                dt_q  <= '0;
                hi_q  <= 1'b0;
                lo_q  <= 1'b0;
            end else if (!run_nx) begin
                tgt_q <= PH_OFF;
                dt_q  <= '0;
                hi_q  <= 1'b0;
                lo_q  <= 1'b0;
            end else if (req != tgt_q) begin
                tgt_q <= req;
                dt_q  <= bus.i_deadtime;
                hi_q  <= bus.i_deadtime == '0 && req == PH_HI && pwm_on;
                lo_q  <= bus.i_deadtime == '0 && req == PH_LO;
            end else begin
                dt_q  <= (dt_q == '0) ? '0 : dt_q - DEADTIME_W'(1);
                hi_q  <= (dt_q <= DEADTIME_W'(1)) && tgt_q == PH_HI && pwm_on;
                lo_q  <= (dt_q <= DEADTIME_W'(1)) && tgt_q == PH_LO;
            end
        end
        assign hi[p] = hi_q;
        assign lo[p] = lo_q;
    end

    assign bus.o_U_hi         = hi[0];
    assign bus.o_U_lo         = lo[0];
    assign bus.o_V_hi         = hi[1];
    assign bus.o_V_lo         = lo[1];
    assign bus.o_W_hi         = hi[2];
    assign bus.o_W_lo         = lo[2];
    assign bus.o_pwm_sync     = sync_q;
    assign bus.o_hall_period  = period_q;
    assign bus.o_period_valid = per_valid_q;
    assign bus.o_fault        = fault_q;
    assign bus.o_state        = state_q;
endmodule

// File: tb/tb_bldc_commutation_engine.sv
// tb_bldc_commutation_engine: directed vectors and sequences for the BLDC commutation engine.
module tb_bldc_commutation_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   uhi, vlo, ulo, wany, pulses;
    logic [31:0] per;
    logic found;
    logic [5:0] gates;

    typedef struct {
        logic [2:0] hall;
        logic       ccw;
        logic [5:0] exp;
    } vec_t;
    vec_t vecs[12];
    logic [2:0] codes[6];

    always #5 clk = ~clk;

    bldc_commutation_engine_if bus ();
    bldc_commutation_engine dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    assign gates = {bus.o_U_hi, bus.o_U_lo, bus.o_V_hi, bus.o_V_lo, bus.o_W_hi, bus.o_W_lo};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if ((gates[5] & gates[4]) | (gates[3] & gates[2]) | (gates[1] & gates[0])) begin
                errors++;
                $display("FAIL shoot_through: gates %b", gates);
            end
            if (bus.o_state != 2'b01 && gates != 6'b0) begin
                errors++;
                $display("FAIL gates_off_when_not_run: state %b gates %b", bus.o_state, gates);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{3'b001, 1'b0, 6'b100100};
        vecs[1]  = '{3'b011, 1'b0, 6'b100001};
        vecs[2]  = '{3'b010, 1'b0, 6'b001001};
        vecs[3]  = '{3'b110, 1'b0, 6'b011000};
        vecs[4]  = '{3'b100, 1'b0, 6'b010010};
        vecs[5]  = '{3'b101, 1'b0, 6'b000110};
        vecs[6]  = '{3'b001, 1'b1, 6'b011000};
        vecs[7]  = '{3'b011, 1'b1, 6'b010010};
        vecs[8]  = '{3'b010, 1'b1, 6'b000110};
        vecs[9]  = '{3'b110, 1'b1, 6'b100100};
        vecs[10] = '{3'b100, 1'b1, 6'b100001};
        vecs[11] = '{3'b101, 1'b1, 6'b001001};
        codes = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};

        bus.i_enable      = 1'b0;
        bus.i_rot_ccw     = 1'b0;
        bus.i_duty        = 12'h400;
        bus.i_deadtime    = 6'd0;
        bus.i_stall_limit = 24'd0;
        bus.i_fault_clear = 1'b0;
        bus.i_hall_state  = 3'b000;
        step(3);
        check("reset_gates", {26'd0, gates}, 0);
        check("reset_misc", {bus.o_state, bus.o_fault, bus.o_pwm_sync, bus.o_period_valid}, 0);
        check("reset_period", bus.o_hall_period, 0);
        rst = 1'b0;

        // Basic CW drive at 25% duty
        bus.i_hall_state = 3'b001;
        bus.i_enable     = 1'b1;
        step(10);
        check("run_state", bus.o_state, 2'b01);
        uhi = 0; vlo = 0; ulo = 0; wany = 0;
        for (int k = 0; k < 4096; k++) begin
            @(negedge clk);
            uhi += bus.o_U_hi;
            vlo += bus.o_V_lo;
            ulo += bus.o_U_lo;
            wany += bus.o_W_hi | bus.o_W_lo;
        end
        check("uhi_count", uhi, 1024);
        check("vlo_count", vlo, 4096);
        check("ulo_count", ulo, 0);
        check("w_count", wany, 0);

        bus.i_duty = 12'h000;
        step(3);
        uhi = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            uhi += bus.o_U_hi;
        end
        check("duty0_uhi", uhi, 0);

        // Dead-time latency on 001 -> 011
        bus.i_duty       = 12'h400;
        bus.i_deadtime   = 6'd10;
        step(2);
        bus.i_hall_state = 3'b011;
        step(3);
        check("vlo_hold_3", bus.o_V_lo, 1);
        step(1);
        check("vlo_fall_4", bus.o_V_lo, 0);
        step(9);
        check("wlo_off_13", bus.o_W_lo, 0);
        step(1);
        check("wlo_on_14", bus.o_W_lo, 1);
        check("ulo_off", bus.o_U_lo, 0);

        // Decode table, both directions; near-full duty so HI reads 1 outside the wrap cycle
        bus.i_duty     = 12'hFFF;
        bus.i_deadtime = 6'd2;
        for (int i = 0; i < 12; i++) begin
            bus.i_hall_state = vecs[i].hall;
            bus.i_rot_ccw    = vecs[i].ccw;
            step(12);
            if (bus.o_pwm_sync) step(1);
            check($sformatf("vec%0d_gates", i), {26'd0, gates}, {26'd0, vecs[i].exp});
        end

        // Period measurement over six CW steps
        bus.i_enable     = 1'b0;
        bus.i_rot_ccw    = 1'b0;
        bus.i_hall_state = 3'b001;
        step(4);
        check("idle_state", bus.o_state, 2'b00);
        bus.i_enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.i_hall_state = codes[i];
            pulses = 0;
            per = 0;
            for (int k = 0; k < 5000; k++) begin
                @(negedge clk);
                if (bus.o_period_valid) begin
                    pulses++;
                    per = bus.o_hall_period;
                end
            end
            check($sformatf("edge%0d_pulses", i + 1), pulses, (i > 0) ? 1 : 0);
            if (i > 0) check($sformatf("edge%0d_period", i + 1), per, 5000);
        end

        // Invalid hall fault and clearing rules
        bus.i_hall_state = 3'b111;
        step(4);
        check("hall_fault_state", bus.o_state, 2'b10);
        check("hall_fault_code", bus.o_fault, 2'b01);
        check("hall_fault_gates", {26'd0, gates}, 0);
        check("period_held", bus.o_hall_period, 5000);
        bus.i_hall_state  = 3'b001;
        bus.i_fault_clear = 1'b1;
        step(3);
        check("clear_ignored", {bus.o_state, bus.o_fault}, 4'b1001);
        bus.i_enable = 1'b0;
        step(1);
        check("clear_idle", {bus.o_state, bus.o_fault}, 4'b0000);
        bus.i_fault_clear = 1'b0;

        // Stall timeout, then disabled stall check
        bus.i_stall_limit = 24'd1000;
        bus.i_enable      = 1'b1;
        step(1000);
        check("stall_not_yet", bus.o_state, 2'b01);
        step(2);
        check("stall_state", bus.o_state, 2'b10);
        check("stall_code", bus.o_fault, 2'b10);
        bus.i_enable      = 1'b0;
        bus.i_fault_clear = 1'b1;
        step(1);
        check("stall_cleared", bus.o_state, 2'b00);
        bus.i_fault_clear = 1'b0;
        bus.i_stall_limit = 24'd0;
        bus.i_enable      = 1'b1;
        step(3000);
        check("stall_disabled", bus.o_state, 2'b01);

        // CCW drive, then async reset while the high side is on
        bus.i_rot_ccw  = 1'b1;
        bus.i_duty     = 12'h400;
        bus.i_deadtime = 6'd0;
        step(10);
        check("ccw_static", {bus.o_U_hi, bus.o_U_lo, bus.o_V_lo, bus.o_W_hi, bus.o_W_lo}, 5'b01000);
        found = 1'b0;
        for (int k = 0; k < 5000 && !found; k++) begin
            @(negedge clk);
            found = bus.o_V_hi;
        end
        check("ccw_vhi_seen", found, 1);
        rst = 1'b1;
        #1;
        check("async_rst_gates", {26'd0, gates}, 0);
        check("async_rst_misc", {bus.o_state, bus.o_fault, bus.o_pwm_sync, bus.o_period_valid}, 0);
        check("async_rst_period", bus.o_hall_period, 0);
        step(2);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
